// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory stage.
//   wb_sel_e    - writeback source select
//   LS_*        - load/store width encodings (funct3)
//   mem_state_e - memory access FSM states
//   ex_mem_t    - EX/MEM stage register contents
package mem_pkg;

  typedef enum logic [1:0] {
    WB_MEM    = 2'b00,
    WB_ALU    = 2'b01,
    WB_PC_INC = 2'b10,
    WB_ZERO   = 2'b11
  } wb_sel_e;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] alu_result;
    logic [31:0] data_2;
    logic        mem_rw;
    logic [2:0]  ls_mode;
    wb_sel_e     wb_sel;
    logic [31:0] pc_inc;
    logic        reg_wr_en;
  } ex_mem_t;

endpackage

// File: rtl/load_store_align.sv
// load_store_align: combinational lane steering for data-memory accesses.
//   i_addr_lo     - low two address bits (byte offset)
//   i_mode        - funct3 width/extension; undefined encodings act as word
//   i_store_data  - rs2 store data
//   i_rdata       - raw bus read data
//   o_be          - byte enables
//   o_wdata       - lane-replicated store data
//   o_load_data   - shifted and extended load result
//   o_misalign    - access not naturally aligned
// The offset used for steering is truncated to natural alignment, so a
// misaligned access that is not trapped still hits a consistent lane.
module load_store_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_mode,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_misalign
);

  logic        w_is_byte;
  logic        w_is_half;
  logic [1:0]  w_off;
  logic [31:0] w_shifted;

  assign w_is_byte = (i_mode == LS_B) || (i_mode == LS_BU);
  assign w_is_half = (i_mode == LS_H) || (i_mode == LS_HU);

  assign w_off = w_is_byte ? i_addr_lo :
                 w_is_half ? {i_addr_lo[1], 1'b0} : 2'b00;

  assign o_be = w_is_byte ? (4'b0001 << w_off) :
                w_is_half ? (4'b0011 << w_off) : 4'b1111;

  assign o_wdata = w_is_byte ? {4{i_store_data[7:0]}} :
                   w_is_half ? {2{i_store_data[15:0]}} : i_store_data;

  assign w_shifted = i_rdata >> {w_off, 3'b000};

  always_comb begin
    o_load_data = w_shifted;
    case (i_mode)
      LS_B:    o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LS_BU:   o_load_data = {24'h0, w_shifted[7:0]};
      LS_H:    o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LS_HU:   o_load_data = {16'h0, w_shifted[15:0]};
      default: o_load_data = w_shifted;
    endcase
  end

  assign o_misalign = (w_is_half & i_addr_lo[0]) |
                      (~w_is_byte & ~w_is_half & (|i_addr_lo));

endmodule

// File: rtl/memory_stage.sv
// memory_stage: EX/MEM register, data-memory access FSM, writeback register.
//   clk, reset (async, active-low)
//   i_*             - execute-stage results
//   o_mem_stall     - hold upstream; stage register does not load
//   o_dmem_*/i_dmem_* - req/gnt/rvalid data-memory bus
//   o_mem_*         - registered writeback fields
// Optional build macro MEMORY_MISALIGN_TRAP_EN: misaligned H/W accesses skip
// the bus and retire with o_mem_misalign=1 and writeback suppressed. Without
// it the offset is truncated to natural alignment and o_mem_misalign is 0.
//
// state | meaning
// IDLE  | request driven when S holds a memory op; store completes on gnt
// RESP  | load granted, waiting for rvalid
module memory_stage
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_valid,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic [XLEN-1:0] i_data_2,
  input  logic            i_mem_rw,
  input  logic [2:0]      i_load_store_mode,
  input  logic [1:0]      i_wb_sel,
  input  logic [XLEN-1:0] i_pc_inc,
  input  logic            i_reg_wr_en,
  output logic            o_mem_stall,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_be,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_mem_valid,
  output logic [31:0]     o_mem_inst,
  output logic [4:0]      o_mem_rd,
  output logic [XLEN-1:0] o_mem_wb_data,
  output logic            o_mem_reg_wr_en,
  output logic            o_mem_misalign
);

  ex_mem_t    r_s;
  ex_mem_t    w_s_next;
  mem_state_e r_state;

  logic        r_w_valid;
  logic [31:0] r_w_inst;
  logic [31:0] r_w_wb_data;
  logic        r_w_reg_wr_en;
  logic        r_w_misalign;

  logic        w_is_store;
  logic        w_is_load;
  logic        w_trap;
  logic        w_memop;
  logic        w_done;
  logic        w_req;
  logic        w_wb_take;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;
  logic [31:0] w_wb_data;
  logic        w_misalign;

  assign w_s_next = '{valid: i_valid, inst: i_inst, alu_result: i_alu_result,
                      data_2: i_data_2, mem_rw: i_mem_rw,
                      ls_mode: i_load_store_mode, wb_sel: wb_sel_e'(i_wb_sel),
                      pc_inc: i_pc_inc, reg_wr_en: i_reg_wr_en};

  load_store_align u_align (
    .i_addr_lo    (r_s.alu_result[1:0]),
    .i_mode       (r_s.ls_mode),
    .i_store_data (r_s.data_2),
    .i_rdata      (i_dmem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data),
    .o_misalign   (w_misalign)
  );

  assign w_is_store = r_s.valid & r_s.mem_rw;
  assign w_is_load  = r_s.valid & (r_s.wb_sel == WB_MEM) & ~r_s.mem_rw;

`ifdef MEMORY_MISALIGN_TRAP_EN
  assign w_trap = (w_is_store | w_is_load) & w_misalign;
`else
  logic w_unused_misalign;
  assign w_unused_misalign = w_misalign;
  assign w_trap = 1'b0;
`endif

  assign w_memop = (w_is_store | w_is_load) & ~w_trap;
  assign w_req   = (r_state == IDLE) & w_memop;
  assign w_done  = ((r_state == IDLE) & w_memop & w_is_store & i_dmem_gnt) |
                   ((r_state == RESP) & i_dmem_rvalid);

  assign o_mem_stall = w_memop & ~w_done;
  assign w_wb_take   = r_s.valid & (~w_memop | w_done);

  // Bus fields are gated by the request so they read 0 when idle.
  assign o_dmem_req   = w_req;
  assign o_dmem_we    = w_req & r_s.mem_rw;
  assign o_dmem_addr  = w_req ? {r_s.alu_result[31:2], 2'b00} : '0;
  assign o_dmem_be    = w_req ? w_be : 4'b0000;
  assign o_dmem_wdata = w_req ? w_wdata : '0;

  always_comb begin
    w_wb_data = '0;
    case (r_s.wb_sel)
      WB_MEM:    w_wb_data = w_load_data;
      WB_ALU:    w_wb_data = r_s.alu_result;
      WB_PC_INC: w_wb_data = r_s.pc_inc;
      default:   w_wb_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_memop && w_is_load && i_dmem_gnt) r_state <= RESP;
        RESP:    if (i_dmem_rvalid) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s <= '0;
    end else if (!o_mem_stall) begin
      r_s <= w_s_next;
    end
  end

  // Misalign flag is cleared with valid so it only ever marks a retiring op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_w_valid     <= 1'b0;
      r_w_inst      <= '0;
      r_w_wb_data   <= '0;
      r_w_reg_wr_en <= 1'b0;
      r_w_misalign  <= 1'b0;
    end else if (w_wb_take) begin
      r_w_valid     <= 1'b1;
      r_w_inst      <= r_s.inst;
      r_w_wb_data   <= w_wb_data;
      r_w_reg_wr_en <= r_s.reg_wr_en & ~w_trap;
      r_w_misalign  <= w_trap;
    end else begin
      r_w_valid     <= 1'b0;
      r_w_reg_wr_en <= 1'b0;
      r_w_misalign  <= 1'b0;
    end
  end

  assign o_mem_valid     = r_w_valid;
  assign o_mem_inst      = r_w_inst;
  assign o_mem_rd        = r_w_inst[11:7];
  assign o_mem_wb_data   = r_w_wb_data;
  assign o_mem_reg_wr_en = r_w_reg_wr_en;
  assign o_mem_misalign  = r_w_misalign;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  logic        clk;
  logic        reset;
  logic        i_valid;
  logic [31:0] i_inst;
  logic [31:0] i_alu_result;
  logic [31:0] i_data_2;
  logic        i_mem_rw;
  logic [2:0]  i_load_store_mode;
  logic [1:0]  i_wb_sel;
  logic [31:0] i_pc_inc;
  logic        i_reg_wr_en;
  logic        o_mem_stall;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_gnt;
  logic        i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic        o_mem_valid;
  logic [31:0] o_mem_inst;
  logic [4:0]  o_mem_rd;
  logic [31:0] o_mem_wb_data;
  logic        o_mem_reg_wr_en;
  logic        o_mem_misalign;

  int n_chk  = 0;
  int n_pass = 0;

  memory_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_inst(i_inst), .i_alu_result(i_alu_result),
    .i_data_2(i_data_2), .i_mem_rw(i_mem_rw),
    .i_load_store_mode(i_load_store_mode), .i_wb_sel(i_wb_sel),
    .i_pc_inc(i_pc_inc), .i_reg_wr_en(i_reg_wr_en),
    .o_mem_stall(o_mem_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be),
    .o_dmem_wdata(o_dmem_wdata), .i_dmem_gnt(i_dmem_gnt),
    .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
    .o_mem_valid(o_mem_valid), .o_mem_inst(o_mem_inst), .o_mem_rd(o_mem_rd),
    .o_mem_wb_data(o_mem_wb_data), .o_mem_reg_wr_en(o_mem_reg_wr_en),
    .o_mem_misalign(o_mem_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] d2, input logic rw,
                       input logic [2:0] mode, input logic [1:0] wbsel,
                       input logic wren);
    i_valid           = 1'b1;
    i_inst            = {20'h0, rd, 7'h03};
    i_alu_result      = alu;
    i_data_2          = d2;
    i_mem_rw          = rw;
    i_load_store_mode = mode;
    i_wb_sel          = wbsel;
    i_pc_inc          = 32'h0000_0100;
    i_reg_wr_en       = wren;
  endtask

  task automatic bubble;
    i_valid     = 1'b0;
    i_mem_rw    = 1'b0;
    i_reg_wr_en = 1'b0;
    i_wb_sel    = 2'b01;
  endtask

  // Load with grant in the first cycle and rvalid in the next.
  task automatic do_load(input string tag, input logic [2:0] mode,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_wb);
    drive(5'd7, addr, 32'h0, 1'b0, mode, 2'b00, 1'b1);
    tick;
    bubble;
    i_dmem_gnt = 1'b1;
    #1;
    chk({tag, " req"}, {31'h0, o_dmem_req}, 32'h1);
    chk({tag, " we"}, {31'h0, o_dmem_we}, 32'h0);
    chk({tag, " addr"}, o_dmem_addr, {addr[31:2], 2'b00});
    chk({tag, " be"}, {28'h0, o_dmem_be}, {28'h0, exp_be});
    chk({tag, " stall req"}, {31'h0, o_mem_stall}, 32'h1);
    tick;
    i_dmem_gnt    = 1'b0;
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata  = rdata;
    #1;
    chk({tag, " stall resp"}, {31'h0, o_mem_stall}, 32'h0);
    tick;
    i_dmem_rvalid = 1'b0;
    chk({tag, " valid"}, {31'h0, o_mem_valid}, 32'h1);
    chk({tag, " wb_data"}, o_mem_wb_data, exp_wb);
    chk({tag, " rd"}, {27'h0, o_mem_rd}, 32'd7);
  endtask

  initial begin
    reset = 1'b0;
    i_valid = 1'b0; i_inst = '0; i_alu_result = '0; i_data_2 = '0;
    i_mem_rw = 1'b0; i_load_store_mode = 3'b000; i_wb_sel = 2'b00;
    i_pc_inc = '0; i_reg_wr_en = 1'b0;
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;

    #12;
    chk("rst valid", {31'h0, o_mem_valid}, 32'h0);
    chk("rst req", {31'h0, o_dmem_req}, 32'h0);
    chk("rst stall", {31'h0, o_mem_stall}, 32'h0);
    chk("rst be", {28'h0, o_dmem_be}, 32'h0);
    chk("rst wb_data", o_mem_wb_data, 32'h0);
    chk("rst wr_en", {31'h0, o_mem_reg_wr_en}, 32'h0);
    chk("rst misalign", {31'h0, o_mem_misalign}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick;

    // ALU op, one-cycle latency
    drive(5'd5, 32'h0000_1234, 32'h0, 1'b0, 3'b010, 2'b01, 1'b1);
    tick;
    bubble;
    #1;
    chk("alu req", {31'h0, o_dmem_req}, 32'h0);
    chk("alu stall", {31'h0, o_mem_stall}, 32'h0);
    tick;
    chk("alu valid", {31'h0, o_mem_valid}, 32'h1);
    chk("alu wb_data", o_mem_wb_data, 32'h0000_1234);
    chk("alu rd", {27'h0, o_mem_rd}, 32'd5);
    chk("alu wr_en", {31'h0, o_mem_reg_wr_en}, 32'h1);
    tick;
    chk("alu valid drop", {31'h0, o_mem_valid}, 32'h0);
    chk("alu wr_en drop", {31'h0, o_mem_reg_wr_en}, 32'h0);
    chk("alu wb_data hold", o_mem_wb_data, 32'h0000_1234);

    // Back-to-back pc_inc and zero selects
    drive(5'd9, 32'hFFFF_0000, 32'h0, 1'b0, 3'b010, 2'b10, 1'b1);
    tick;
    drive(5'd10, 32'hFFFF_0000, 32'h0, 1'b0, 3'b010, 2'b11, 1'b1);
    tick;
    bubble;
    chk("pcinc wb_data", o_mem_wb_data, 32'h0000_0100);
    chk("pcinc rd", {27'h0, o_mem_rd}, 32'd9);
    tick;
    chk("zero wb_data", o_mem_wb_data, 32'h0);
    chk("zero valid", {31'h0, o_mem_valid}, 32'h1);

    // SB at 0x1003 with grant withheld for two cycles
    drive(5'd0, 32'h0000_1003, 32'h0000_00AB, 1'b1, 3'b000, 2'b01, 1'b0);
    tick;
    bubble;
    #1;
    chk("sb req c1", {31'h0, o_dmem_req}, 32'h1);
    chk("sb we", {31'h0, o_dmem_we}, 32'h1);
    chk("sb addr", o_dmem_addr, 32'h0000_1000);
    chk("sb be", {28'h0, o_dmem_be}, 32'h8);
    chk("sb wdata", o_dmem_wdata, 32'hABAB_ABAB);
    chk("sb stall c1", {31'h0, o_mem_stall}, 32'h1);
    tick;
    chk("sb req c2", {31'h0, o_dmem_req}, 32'h1);
    chk("sb stall c2", {31'h0, o_mem_stall}, 32'h1);
    chk("sb valid c2", {31'h0, o_mem_valid}, 32'h0);
    tick;
    chk("sb req c3", {31'h0, o_dmem_req}, 32'h1);
    chk("sb addr c3", o_dmem_addr, 32'h0000_1000);
    i_dmem_gnt = 1'b1;
    #1;
    chk("sb stall gnt", {31'h0, o_mem_stall}, 32'h0);
    tick;
    i_dmem_gnt = 1'b0;
    chk("sb valid", {31'h0, o_mem_valid}, 32'h1);
    chk("sb wr_en", {31'h0, o_mem_reg_wr_en}, 32'h0);
    chk("sb req after", {31'h0, o_dmem_req}, 32'h0);

    // SH at 0x1002, immediate grant
    drive(5'd0, 32'h0000_1002, 32'h1234_ABCD, 1'b1, 3'b001, 2'b01, 1'b0);
    tick;
    bubble;
    i_dmem_gnt = 1'b1;
    #1;
    chk("sh be", {28'h0, o_dmem_be}, 32'hC);
    chk("sh wdata", o_dmem_wdata, 32'hABCD_ABCD);
    tick;
    i_dmem_gnt = 1'b0;
    chk("sh valid", {31'h0, o_mem_valid}, 32'h1);

    do_load("lb", 3'b000, 32'h0000_2002, 32'h0080_FF00, 4'b0100, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h0000_2002, 32'h0080_FF00, 4'b0100, 32'h0000_0080);
    do_load("lhu", 3'b101, 32'h0000_2002, 32'hBEEF_1234, 4'b1100, 32'h0000_BEEF);
    do_load("lh", 3'b001, 32'h0000_2000, 32'h0000_8001, 4'b0011, 32'hFFFF_8001);
    do_load("lw", 3'b010, 32'h0000_2004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_load("lw undef mode", 3'b111, 32'h0000_2008, 32'h0102_0304, 4'b1111, 32'h0102_0304);

`ifdef MEMORY_MISALIGN_TRAP_EN
    drive(5'd7, 32'h0000_3001, 32'h0, 1'b0, 3'b010, 2'b00, 1'b1);
    tick;
    bubble;
    #1;
    chk("lw mis req", {31'h0, o_dmem_req}, 32'h0);
    chk("lw mis stall", {31'h0, o_mem_stall}, 32'h0);
    tick;
    chk("lw mis valid", {31'h0, o_mem_valid}, 32'h1);
    chk("lw mis flag", {31'h0, o_mem_misalign}, 32'h1);
    chk("lw mis wr_en", {31'h0, o_mem_reg_wr_en}, 32'h0);
`else
    do_load("lw mis", 3'b010, 32'h0000_3001, 32'h1122_3344, 4'b1111, 32'h1122_3344);
    chk("lw mis flag", {31'h0, o_mem_misalign}, 32'h0);
`endif

    // Reset while waiting for rvalid, then a stray rvalid
    drive(5'd7, 32'h0000_2000, 32'h0, 1'b0, 3'b010, 2'b00, 1'b1);
    tick;
    bubble;
    i_dmem_gnt = 1'b1;
    tick;
    i_dmem_gnt = 1'b0;
    reset = 1'b0;
    #2;
    chk("rst resp stall", {31'h0, o_mem_stall}, 32'h0);
    chk("rst resp valid", {31'h0, o_mem_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata  = 32'hFFFF_FFFF;
    tick;
    i_dmem_rvalid = 1'b0;
    chk("stray valid", {31'h0, o_mem_valid}, 32'h0);
    chk("stray wr_en", {31'h0, o_mem_reg_wr_en}, 32'h0);
    chk("stray wb_data", o_mem_wb_data, 32'h0);
    chk("stray req", {31'h0, o_dmem_req}, 32'h0);

    // Stage back in IDLE: an aligned load runs normally
    do_load("post rst lw", 3'b010, 32'h0000_200C, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Captures execute results into an EX/MEM register.
- Performs data-memory loads and stores over a req/gnt/rvalid bus, and aligns and extends load data.
- Produces registered writeback fields for the writeback stage.
- Stalls upstream while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  execute output holds a real instruction (0 = bubble).
- i_inst  in  32  instruction word.
- i_alu_result  in  32  effective address, or ALU result.
- i_data_2  in  32  store data (rs2).
- i_mem_rw  in  1  1 = store.
- i_load_store_mode  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_wb_sel  in  2  00 mem, 01 alu, 10 pc_inc, 11 zero.
- i_pc_inc  in  32  PC+4.
- i_reg_wr_en  in  1  register write enable.
- o_mem_stall  out  1  upstream must hold its inputs; stage register does not load.
- o_dmem_req  out  1  bus request.
- o_dmem_we  out  1  request is a write.
- o_dmem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- o_dmem_be  out  4  byte enables.
- o_dmem_wdata  out  32  lane-replicated store data.
- i_dmem_gnt  in  1  request accepted this cycle.
- i_dmem_rvalid  in  1  read data valid.
- i_dmem_rdata  in  32  read data.
- o_mem_valid  out  1  writeback fields valid.
- o_mem_inst  out  32  instruction word.
- o_mem_rd  out  5  inst[11:7].
- o_mem_wb_data  out  32  selected writeback value.
- o_mem_reg_wr_en  out  1  writeback enable, already gated by o_mem_valid.
- o_mem_misalign  out  1  misaligned access flag.

Behaviour:
- Stage register S (valid plus all input fields) loads on every edge where o_mem_stall=0.
- Derived signals: is_store = S.valid & S.mem_rw; is_load = S.valid & S.wb_sel==00 & ~S.mem_rw; memop = is_store | is_load.
- FSM states:
  - IDLE: o_dmem_req=memop. On gnt: store → done this cycle, stay IDLE; load → RESP.
  - RESP: o_dmem_req=0. On i_dmem_rvalid → done, capture data, go to IDLE.
- i_dmem_rvalid in IDLE is ignored.
- o_mem_stall = memop & ~done.
- While requesting, addr/we/be/wdata are held stable until gnt.
- Byte enables, with off = addr[1:0]:
  - B: 0001<<off.
  - H: 0011<<off.
  - W: 1111.
- Store data:
  - B: byte replicated ×4.
  - H: halfword replicated ×2.
  - W: as is.
- Load data: rdata >> (8·off), then sign-extend (B/H) or zero-extend (BU/HU); W passes through.
- Output register W:
  - On an edge where S is valid and (non-memop or done), W captures inst, rd, wb_data, reg_wr_en, valid=1.
  - Otherwise W.valid=0 and W.reg_wr_en=0; other W fields hold.
- Latency:
  - Non-memory instruction: input edge k → o_mem_valid at edge k+1.
  - Load with gnt in first cycle and rvalid the next: o_mem_valid at edge k+2.
  - Store with immediate gnt: o_mem_valid at edge k+1.
- Undefined load_store_mode values (011, 110, 111) are treated as W.
- Reset value of every output and register is 0. State = IDLE. S.valid = W.valid = 0.
- Reset mid-access abandons the transaction; a later stray rvalid is ignored.
- Back-to-back memory operations: the next one issues the cycle after done, because S reloads on the done edge.

Optional Feature:
- Macro MEMORY_MISALIGN_TRAP_EN.
- Misaligned access is defined as H with addr[0]=1, or W with addr[1:0]≠00.
- Defined:
  - A misaligned access issues no bus request and no stall.
  - W loads next edge with o_mem_misalign=1 and o_mem_reg_wr_en=0.
- Undefined:
  - The offset is truncated to natural alignment (H: addr[1],0; W: 00) and the access proceeds normally.
  - o_mem_misalign is tied 0.

Decomposition:
- Package mem_pkg holds:
  - wb_sel_e: WB_MEM, WB_ALU, WB_PC_INC, WB_ZERO.
  - LS_B/H/W/BU/HU constants.
  - mem_state_e: IDLE, RESP.
  - The EX/MEM struct typedef.
- One combinational sub-module, load_store_align: computes byte enables, store replication, load shift/extend, and the misalign flag.

Test Plan:
- ALU op with wb_sel=01, alu_result=0x1234, rd=5, gnt unused → next edge: o_mem_valid=1, wb_data=0x1234, no req, no stall.
- SB at 0x1003, rs2=0xAB, gnt held low for 2 cycles → req held 3 cycles with addr=0x1000, be=1000, wdata=0xABABABAB; stall=1 until gnt.
- LB at 0x2002, gnt immediate, rvalid 1 cycle later with rdata=0x0080FF00 → wb_data=0xFFFFFF80. The same access as LBU → wb_data=0x00000080.
- LHU at 0x2002, rdata=0xBEEF1234 → wb_data=0x0000BEEF, be=1100.
- LW at 0x3001:
  - With macro: no req, o_mem_misalign=1, reg_wr_en=0.
  - Without macro: addr=0x3000, be=1111.
- Assert reset low while in RESP, then release and pulse rvalid → state IDLE, o_mem_valid=0, no writeback.
